neuron_param_loader: RTL and testbench

- Transmitter for the neuron weight/bias load interface.
- Accepts a packed parameter stream (valid/ready, last-flagged) from the AXI side and serialises it to all neurons of one layer.
- Per neuron it drives NUM_WEIGHTS weight beats, then one bias beat.
- Neurons filter weights by config_layer_num/config_neuron_num. Bias strobes are one-hot per neuron, because a neuron latches bias on any biasValid.

---
 rtl/neuron_param_loader.sv | 137 +++++++++++++
 tb/tb_neuron_param_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_param_loader.sv
// neuron_param_loader: serialises a packed weight/bias stream to one layer.
// Ports: clk, rst_n (sync, active low), start; stream s_tdata/s_tvalid/
//   s_tlast/s_tready; neuron side weight_value/weight_valid, bias_value,
//   bias_valid (one-hot per neuron), config_layer_num, config_neuron_num;
//   status busy, done (pulse), error (sticky framing error).
// Optional: define LOADER_CHECKSUM_EN to add a 32-bit running checksum port.
module neuron_param_loader #(
    parameter int DATA_WIDTH  = 16,
    parameter int CFG_WIDTH   = 33,
    parameter int LAYER_NO    = 1,
    parameter int NUM_NEURONS = 32,
    parameter int NUM_WEIGHTS = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [DATA_WIDTH-1:0]  s_tdata,
    input  logic                   s_tvalid,
    input  logic                   s_tlast,
    output logic                   s_tready,
    output logic [DATA_WIDTH-1:0]  weight_value,
    output logic                   weight_valid,
    output logic [DATA_WIDTH-1:0]  bias_value,
    output logic [NUM_NEURONS-1:0] bias_valid,
    output logic [CFG_WIDTH-1:0]   config_layer_num,
    output logic [CFG_WIDTH-1:0]   config_neuron_num,
    output logic                   busy,
    output logic                   done,
    output logic                   error
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [31:0]            checksum
`endif
);

    localparam int WW = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1;
    localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [WW-1:0] LAST_W = WW'(NUM_WEIGHTS - 1);
    localparam logic [NW-1:0] LAST_N = NW'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {
        IDLE,
        WEIGHT,
        BIAS,
        FINISH
    } state_t;

    state_t        state;
    logic [WW-1:0] wcnt;
    logic [NW-1:0] ncnt;
    logic          hs;

    assign s_tready = (state == WEIGHT) || (state == BIAS);
    assign hs       = s_tvalid & s_tready;
    assign busy     = (state != IDLE);
    assign config_layer_num = busy ? CFG_WIDTH'(LAYER_NO) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= IDLE;
            wcnt              <= '0;
            ncnt              <= '0;
            weight_value      <= '0;
            weight_valid      <= 1'b0;
            bias_value        <= '0;
            bias_valid        <= '0;
            config_neuron_num <= '0;
            done              <= 1'b0;
            error             <= 1'b0;
        end else begin
            weight_valid <= 1'b0;
            bias_valid   <= '0;
            done         <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        error <= 1'b0;
                        wcnt  <= '0;
                        ncnt  <= '0;
                        state <= WEIGHT;
                    end
                end
                WEIGHT: begin
                    if (hs) begin
                        weight_valid      <= 1'b1;
                        weight_value      <= s_tdata;
                        config_neuron_num <= CFG_WIDTH'(ncnt);
                        // Early tlast: emit the word, then abort the load.
                        if (s_tlast) begin
                            error <= 1'b1;
                            state <= FINISH;
                        end else if (wcnt == LAST_W) begin
                            state <= BIAS;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                BIAS: begin
                    if (hs) begin
                        bias_valid        <= NUM_NEURONS'(1) << ncnt;
                        bias_value        <= s_tdata;
                        config_neuron_num <= CFG_WIDTH'(ncnt);
                        if (ncnt == LAST_N) begin
                            if (!s_tlast) error <= 1'b1;
                            state <= FINISH;
                        end else if (s_tlast) begin
                            error <= 1'b1;
                            state <= FINISH;
                        end else begin
                            ncnt  <= ncnt + 1'b1;
                            wcnt  <= '0;
                            state <= WEIGHT;
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (state == IDLE && start) begin
            checksum <= '0;
        end else if (hs) begin
            checksum <= checksum + 32'(s_tdata);
        end
    end
`endif

endmodule

// File: tb/tb_neuron_param_loader.sv
// tb_neuron_param_loader: table-driven loads with a strobe scoreboard.
// Small layer (2 neurons x 4 weights) so every boundary is reached quickly.
module tb_neuron_param_loader;

    localparam int DW    = 16;
    localparam int CW    = 33;
    localparam int LN    = 1;
    localparam int NN    = 2;
    localparam int NWT   = 4;
    localparam int BEATS = NN * (NWT + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic          s_tready;
    logic [DW-1:0] weight_value;
    logic          weight_valid;
    logic [DW-1:0] bias_value;
    logic [NN-1:0] bias_valid;
    logic [CW-1:0] config_layer_num;
    logic [CW-1:0] config_neuron_num;
    logic          busy;
    logic          done;
    logic          error;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]   checksum;
    logic [31:0]   cs_exp;
`endif

    neuron_param_loader #(
        .DATA_WIDTH(DW), .CFG_WIDTH(CW), .LAYER_NO(LN),
        .NUM_NEURONS(NN), .NUM_WEIGHTS(NWT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(s_tready),
        .weight_value(weight_value), .weight_valid(weight_valid),
        .bias_value(bias_value), .bias_valid(bias_valid),
        .config_layer_num(config_layer_num),
        .config_neuron_num(config_neuron_num),
        .busy(busy), .done(done), .error(error)
`ifdef LOADER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic          is_bias;
        logic [DW-1:0] val;
        logic [NN-1:0] bv;
        logic [CW-1:0] nn;
    } exp_t;

    typedef struct {
        bit gap;
        int tlast_at;
        int exp_beats;
        bit exp_err;
    } vec_t;

    exp_t q[$];
    vec_t vecs[5];
    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_strobe = 0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic monitor();
        exp_t e;
        logic [DW-1:0] v;
        forever begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (weight_valid || (|bias_valid)) begin
                last_strobe = cyc;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL stray strobe: cyc %0d wv %0b bv %0b",
                             cyc, weight_valid, bias_valid);
                end else begin
                    e = q.pop_front();
                    v = e.is_bias ? bias_value : weight_value;
                    chk("strobe", {cyc, weight_valid, bias_valid, v,
                                   config_neuron_num},
                        {e.cyc, ~e.is_bias, e.bv, e.val, e.nn});
                    chk("layer num", config_layer_num, CW'(LN));
                end
            end
        end
    endtask

    // Expected strobe for beat i of a load, derived from the beat index.
    function automatic void push(int i, logic [DW-1:0] d);
        exp_t e;
        int n;
        int p;
        n = i / (NWT + 1);
        p = i % (NWT + 1);
        e.cyc = cyc + 1;
        e.is_bias = (p == NWT);
        e.val = d;
        e.bv = e.is_bias ? NN'(1) << n : '0;
        e.nn = CW'(n);
        q.push_back(e);
    endfunction

    task automatic send_word(int i, bit gap, bit last, output bit ok);
        int t;
        t = 0;
        if (gap) begin
            s_tvalid = 1'b0;
            @(negedge clk);
        end
        s_tdata  = DW'(i + 1);
        s_tlast  = last;
        s_tvalid = 1'b1;
        while (!s_tready && t < 20) begin
            @(negedge clk);
            t++;
        end
        ok = s_tready;
        if (ok) begin
            push(i, s_tdata);
`ifdef LOADER_CHECKSUM_EN
            cs_exp = cs_exp + 32'(s_tdata);
`endif
            @(negedge clk);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        cs_exp = '0;
`endif
    endtask

    task automatic run_vec(vec_t v);
        int acc;
        int d0;
        int t;
        bit ok;
        acc = 0;
        d0 = done_cnt;
        pulse_start();
        chk("busy after start", busy, 1'b1);
        chk("error after start", error, 1'b0);
        for (int i = 0; i < BEATS; i++) begin
            send_word(i, v.gap, i == v.tlast_at, ok);
            if (!ok) break;
            acc++;
        end
        t = 0;
        while (done_cnt == d0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("beats accepted", acc, v.exp_beats);
        chk("done count", done_cnt - d0, 1);
        chk("done timing", done_cyc, last_strobe + 1);
        chk("error", error, v.exp_err);
        chk("queue empty", q.size(), 0);
        chk("idle flags", {busy, s_tready, config_layer_num}, '0);
`ifdef LOADER_CHECKSUM_EN
        chk("checksum", checksum, cs_exp);
`endif
    endtask

    initial begin
        int d0;
        bit ok;
        vecs[0] = '{gap: 1'b0, tlast_at: BEATS - 1, exp_beats: BEATS, exp_err: 1'b0};
        vecs[1] = '{gap: 1'b1, tlast_at: BEATS - 1, exp_beats: BEATS, exp_err: 1'b0};
        vecs[2] = '{gap: 1'b0, tlast_at: 2, exp_beats: 3, exp_err: 1'b1};
        vecs[3] = '{gap: 1'b0, tlast_at: -1, exp_beats: BEATS, exp_err: 1'b1};
        vecs[4] = '{gap: 1'b0, tlast_at: NWT, exp_beats: NWT + 1, exp_err: 1'b1};
`ifdef LOADER_CHECKSUM_EN
        cs_exp = '0;
`endif
        fork
            monitor();
        join_none

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset outputs", {weight_valid, weight_value, bias_valid,
                              bias_value, config_layer_num,
                              config_neuron_num, busy, done, error,
                              s_tready}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) run_vec(vecs[v]);

        // Reset after word 6 (first weight of neuron 1) aborts the load.
        d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 6; i++) send_word(i, 1'b0, 1'b0, ok);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid-load reset", {weight_valid, bias_valid, config_layer_num,
                               config_neuron_num, busy, done, error,
                               s_tready}, '0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("no done after reset", done_cnt, d0);
        chk("queue after reset", q.size(), 0);
        run_vec(vecs[0]);

`ifdef LOADER_CHECKSUM_EN
        pulse_start();
        chk("checksum cleared", checksum, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
